sub_pipe: RTL

- Two-stage pipelined 32-bit subtractor (diff = a - b); the inverse-direction companion of the 32-bit lookahead adder in the ALU datapath.
- Computed as a + ~b + 1, split at bit 16: low half in stage 1, high half in stage 2 using the registered inter-half carry.
- Valid/ready handshake on both sides; full throughput (1 op/cycle); produces borrow, overflow, zero and negative flags for the ALU flag logic.

---
 rtl/sub_pipe_pkg.sv | 29 ++
 rtl/sub_half16.sv | 69 ++++++
 rtl/sub_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sub_pipe_pkg.sv
// Shared ALU definitions for the subtract datapath.
// Contents: datapath widths, the ALU flag bundle, and a helper that derives
// the flags from a finished 32-bit difference.
package sub_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef struct packed {
    logic borrow;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  // a31/b31 are the operand sign bits. c32 is the carry out of a + ~b + 1.
  function automatic alu_flags_t calc_flags(input logic [DATA_W-1:0] diff,
                                            input logic a31,
                                            input logic b31,
                                            input logic c32);
    alu_flags_t f;
    f.borrow   = ~c32;
    f.overflow = (a31 != b31) && (diff[DATA_W-1] != a31);
    f.zero     = (diff == '0);
    f.negative = diff[DATA_W-1];
    return f;
  endfunction

endpackage

// File: rtl/sub_half16.sv
// 16-bit carry-lookahead adder: sum = a + nb + cin.
// Ports:
//   a    [15:0] in  first operand
//   nb   [15:0] in  second operand (already inverted by the caller when subtracting)
//   cin         in  carry in
//   sum  [15:0] out sum bits
//   cout        out carry out of bit 15
// Internally the operands form four 4-bit propagate/generate groups.
// A second lookahead level spans those groups.
module sub_half16
  import sub_pipe_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] nb,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  logic [HALF_W-1:0] p;
  logic [HALF_W-1:0] g;
  logic [HALF_W-1:0] c;
  logic [3:0]        gp;
  logic [3:0]        gg;
  logic [4:0]        gc;

  assign p = a ^ nb;
  assign g = a & nb;

  always_comb begin
    gp = '0;
    gg = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Group-level lookahead: each group carry comes straight from cin.
  // No ripple through the groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/sub_pipe.sv
// Two-stage pipelined 32-bit subtractor: diff = a - b, computed as a + ~b + 1.
// Stage 1 adds the low half. It registers the low result, the carry into bit 16,
// the high-half operands and the tag. Stage 2 adds the high half and registers
// the full result plus the ALU flags.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               sync; drops both stages, blocks input that cycle
//   in_valid/in_ready   input handshake; a, b, in_tag are the operation
//   out_valid/out_ready output handshake; diff, out_tag, flags are the result
//   borrow, overflow, zero, negative  flags of the registered result
module sub_pipe
  import sub_pipe_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic [TAG_W-1:0]  out_tag,
  output logic              borrow,
  output logic              overflow,
  output logic              zero,
  output logic              negative
);

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_adv;
  logic              s2_adv;

  logic [HALF_W-1:0] s1_diff_lo;
  logic              s1_c16;
  logic [HALF_W-1:0] s1_a_hi;
  logic [HALF_W-1:0] s1_nb_hi;
  logic              s1_a31;
  logic              s1_b31;
  logic [TAG_W-1:0]  s1_tag;

  logic [HALF_W-1:0] lo_sum;
  logic              lo_cout;
  logic [HALF_W-1:0] hi_sum;
  logic              hi_cout;
  logic [HALF_W-1:0] nb_lo;
  logic [DATA_W-1:0] full_diff;
  alu_flags_t        s2_flags_next;
  alu_flags_t        out_flags;

  // A stage moves when its downstream slot is free or is being emptied.
  // This lets a full pipeline accept and emit in the same cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush;

  assign nb_lo = ~b[HALF_W-1:0];

  sub_half16 u_lo (
    .a    (a[HALF_W-1:0]),
    .nb   (nb_lo),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  sub_half16 u_hi (
    .a    (s1_a_hi),
    .nb   (s1_nb_hi),
    .cin  (s1_c16),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign full_diff     = {hi_sum, s1_diff_lo};
  assign s2_flags_next = calc_flags(full_diff, s1_a31, s1_b31, hi_cout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_c16     <= 1'b0;
      s1_a_hi    <= '0;
      s1_nb_hi   <= '0;
      s1_a31     <= 1'b0;
      s1_b31     <= 1'b0;
      s1_tag     <= '0;
      diff       <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (flush) begin
      // Data registers keep stale values; only the valid bits matter.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          diff      <= full_diff;
          out_tag   <= s1_tag;
          out_flags <= s2_flags_next;
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_diff_lo <= lo_sum;
          s1_c16     <= lo_cout;
          s1_a_hi    <= a[DATA_W-1:HALF_W];
          s1_nb_hi   <= ~b[DATA_W-1:HALF_W];
          s1_a31     <= a[DATA_W-1];
          s1_b31     <= b[DATA_W-1];
          s1_tag     <= in_tag;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign borrow    = out_flags.borrow;
  assign overflow  = out_flags.overflow;
  assign zero      = out_flags.zero;
  assign negative  = out_flags.negative;

endmodule
